wb_sdram_arbiter: RTL and testbench

Two-port arbiter between a pair of Wishbone-to-SDRAM port blocks and the single SDRAM controller, all in the SDRAM clock domain. It grants the controller interface to one port at a time with round-robin fairness, and holds the grant across a port's complete two-burst read sequence. It assembles each granted 32-bit write from its two 16-bit halves and broadcasts it to the other port's buffer-write interface, so that port's read buffer stays coherent.

---
 rtl/wb_sdram_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter between two Wishbone-to-SDRAM port blocks and one SDRAM controller.
// Assembles granted 32-bit writes and broadcasts them to the other port's read buffer.
module wb_sdram_arbiter #(
  parameter int unsigned READ_HOLD = 8
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst_n,
  input  logic [31:0] p0_adr_i,
  input  logic [15:0] p0_dat_i,
  input  logic [1:0]  p0_sel_i,
  input  logic        p0_acc_i,
  input  logic        p0_we_i,
  output logic        p0_ack_o,
  output logic [15:0] p0_dat_o,
  output logic        p0_bufw_we_o,
  input  logic [31:0] p1_adr_i,
  input  logic [15:0] p1_dat_i,
  input  logic [1:0]  p1_sel_i,
  input  logic        p1_acc_i,
  input  logic        p1_we_i,
  output logic        p1_ack_o,
  output logic [15:0] p1_dat_o,
  output logic        p1_bufw_we_o,
  output logic [31:0] bufw_adr_o,
  output logic [31:0] bufw_dat_o,
  output logic [3:0]  bufw_sel_o,
  output logic [31:0] sdr_adr_o,
  output logic [15:0] sdr_dat_o,
  output logic [1:0]  sdr_sel_o,
  output logic        sdr_acc_o,
  output logic        sdr_we_o,
  input  logic        sdr_ack_i,
  input  logic [15:0] sdr_dat_i
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(READ_HOLD - 1);

  state_t      state_q;
  logic        gnt_q;
  logic        last_q;
  logic        rd_acked_q;
  logic [3:0]  idle_cnt_q;
  logic [15:0] hi_dat_q;
  logic [1:0]  hi_sel_q;
  logic [31:0] wr_adr_q;
  logic [31:0] bufw_adr_q;
  logic [31:0] bufw_dat_q;
  logic [3:0]  bufw_sel_q;
  logic        p0_bufw_we_q;
  logic        p1_bufw_we_q;

  logic        busy_s;
  logic        pick_s;
  logic [31:0] g_adr_s;
  logic [15:0] g_dat_s;
  logic [1:0]  g_sel_s;
  logic        g_acc_s;
  logic        g_we_s;
  logic        wr_ack_s;
  logic        rd_ack_s;

  assign busy_s   = (state_q == BUSY);
  assign pick_s   = (p0_acc_i & p1_acc_i) ? ~last_q : p1_acc_i;
  assign g_adr_s  = gnt_q ? p1_adr_i : p0_adr_i;
  assign g_dat_s  = gnt_q ? p1_dat_i : p0_dat_i;
  assign g_sel_s  = gnt_q ? p1_sel_i : p0_sel_i;
  assign g_acc_s  = gnt_q ? p1_acc_i : p0_acc_i;
  assign g_we_s   = gnt_q ? p1_we_i  : p0_we_i;
  assign wr_ack_s = g_acc_s & g_we_s & sdr_ack_i;
  assign rd_ack_s = g_acc_s & ~g_we_s & sdr_ack_i;

  assign sdr_adr_o = busy_s ? g_adr_s : 32'h0000_0000;
  assign sdr_dat_o = busy_s ? g_dat_s : 16'h0000;
  assign sdr_sel_o = busy_s ? g_sel_s : 2'b00;
  assign sdr_acc_o = busy_s & g_acc_s;
  assign sdr_we_o  = busy_s & g_we_s;
  assign p0_ack_o  = busy_s & ~gnt_q & sdr_ack_i;
  assign p1_ack_o  = busy_s & gnt_q & sdr_ack_i;
  assign p0_dat_o  = sdr_dat_i;
  assign p1_dat_o  = sdr_dat_i;

  assign bufw_adr_o   = bufw_adr_q;
  assign bufw_dat_o   = bufw_dat_q;
  assign bufw_sel_o   = bufw_sel_q;
  assign p0_bufw_we_o = p0_bufw_we_q;
  assign p1_bufw_we_o = p1_bufw_we_q;

  // Grant FSM, write assembly, read-hold timer and buffer-write strobe generation
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;
      rd_acked_q   <= 1'b0;
      idle_cnt_q   <= 4'd0;
      hi_dat_q     <= 16'h0000;
      hi_sel_q     <= 2'b00;
      wr_adr_q     <= 32'h0000_0000;
      bufw_adr_q   <= 32'h0000_0000;
      bufw_dat_q   <= 32'h0000_0000;
      bufw_sel_q   <= 4'h0;
      p0_bufw_we_q <= 1'b0;
      p1_bufw_we_q <= 1'b0;
    end else begin
      p0_bufw_we_q <= 1'b0;
      p1_bufw_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (p0_acc_i | p1_acc_i) begin
            state_q    <= BUSY;
            gnt_q      <= pick_s;
            last_q     <= pick_s;
            idle_cnt_q <= 4'd0;
            rd_acked_q <= 1'b0;
          end
        end
        BUSY: begin
          if (wr_ack_s) begin
            state_q      <= IDLE;
            bufw_dat_q   <= {hi_dat_q, g_dat_s};
            bufw_sel_q   <= {hi_sel_q, g_sel_s};
            bufw_adr_q   <= wr_adr_q;
            p0_bufw_we_q <= gnt_q;
            p1_bufw_we_q <= ~gnt_q;
          end else if (g_acc_s & g_we_s) begin
            hi_dat_q <= g_dat_s;
            hi_sel_q <= g_sel_s;
            wr_adr_q <= {g_adr_s[31:2], 2'b00};
          end
          if (rd_ack_s) begin
            rd_acked_q <= 1'b1;
          end
          // After the first read ack, the grant survives only a run of READ_HOLD idle cycles
          if (rd_acked_q) begin
            if (g_acc_s) begin
              idle_cnt_q <= 4'd0;
            end else if (idle_cnt_q == HOLD_LAST) begin
              state_q <= IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_wb_sdram_arbiter;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  acc;
  logic [1:0]  we;
  logic [31:0] adr [2];
  logic [15:0] dat [2];
  logic [1:0]  sel [2];
  logic        sdr_ack;
  logic [15:0] sdr_rdat;

  logic        p0_ack_o, p1_ack_o, p0_bufw_we_o, p1_bufw_we_o;
  logic [15:0] p0_dat_o, p1_dat_o, sdr_dat_o;
  logic [31:0] bufw_adr_o, bufw_dat_o, sdr_adr_o;
  logic [3:0]  bufw_sel_o;
  logic [1:0]  sdr_sel_o;
  logic        sdr_acc_o, sdr_we_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_owner;
  int          m_prev;
  int          m_low;
  bit          m_rd;
  logic [15:0] m_hi;
  logic [1:0]  m_hisel;
  logic [31:0] m_wadr;
  logic [31:0] m_badr;
  logic [31:0] m_bdat;
  logic [3:0]  m_bsel;
  logic [1:0]  m_stb;

  wb_sdram_arbiter #(.READ_HOLD(HOLD)) dut (
    .sdram_clk    (clk),
    .sdram_rst_n  (rst_n),
    .p0_adr_i     (adr[0]),
    .p0_dat_i     (dat[0]),
    .p0_sel_i     (sel[0]),
    .p0_acc_i     (acc[0]),
    .p0_we_i      (we[0]),
    .p0_ack_o     (p0_ack_o),
    .p0_dat_o     (p0_dat_o),
    .p0_bufw_we_o (p0_bufw_we_o),
    .p1_adr_i     (adr[1]),
    .p1_dat_i     (dat[1]),
    .p1_sel_i     (sel[1]),
    .p1_acc_i     (acc[1]),
    .p1_we_i      (we[1]),
    .p1_ack_o     (p1_ack_o),
    .p1_dat_o     (p1_dat_o),
    .p1_bufw_we_o (p1_bufw_we_o),
    .bufw_adr_o   (bufw_adr_o),
    .bufw_dat_o   (bufw_dat_o),
    .bufw_sel_o   (bufw_sel_o),
    .sdr_adr_o    (sdr_adr_o),
    .sdr_dat_o    (sdr_dat_o),
    .sdr_sel_o    (sdr_sel_o),
    .sdr_acc_o    (sdr_acc_o),
    .sdr_we_o     (sdr_we_o),
    .sdr_ack_i    (sdr_ack),
    .sdr_dat_i    (sdr_rdat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock, applying the arbitration/assembly rules to current inputs.
  function automatic void model_update();
    int o;
    bit a;
    bit w;
    if (!rst_n) begin
      m_owner = -1; m_prev = 1; m_low = 0; m_rd = 1'b0;
      m_hi = 16'h0; m_hisel = 2'b00; m_wadr = 32'h0;
      m_badr = 32'h0; m_bdat = 32'h0; m_bsel = 4'h0; m_stb = 2'b00;
    end else begin
      m_stb = 2'b00;
      if (m_owner < 0) begin
        if (acc != 2'b00) begin
          if (acc == 2'b11) o = 1 - m_prev;
          else o = acc[1] ? 1 : 0;
          m_owner = o; m_prev = o; m_low = 0; m_rd = 1'b0;
        end
      end else begin
        o = m_owner;
        a = acc[o];
        w = we[o];
        if (a && w && sdr_ack) begin
          m_bdat = {m_hi, dat[o]};
          m_bsel = {m_hisel, sel[o]};
          m_badr = m_wadr;
          m_stb[1 - o] = 1'b1;
          m_owner = -1;
        end else if (a && w) begin
          m_hi = dat[o]; m_hisel = sel[o]; m_wadr = {adr[o][31:2], 2'b00};
        end
        if (m_rd) begin
          if (a) m_low = 0;
          else begin
            m_low++;
            if (m_low == HOLD) m_owner = -1;
          end
        end
        if (a && !w && sdr_ack) m_rd = 1'b1;
      end
    end
  endfunction

  task automatic model_compare();
    int o;
    o = m_owner;
    if (o < 0) begin
      check("m_sdr_ctl", 128'({sdr_acc_o, sdr_we_o}), 128'(2'b00));
      check("m_acks", 128'({p1_ack_o, p0_ack_o}), 128'(2'b00));
    end else begin
      check("m_sdr", 128'({sdr_acc_o, sdr_we_o, sdr_sel_o, sdr_dat_o, sdr_adr_o}),
            128'({acc[o], we[o], sel[o], dat[o], adr[o]}));
      check("m_acks", 128'({p1_ack_o, p0_ack_o}),
            128'((o == 1) ? {sdr_ack, 1'b0} : {1'b0, sdr_ack}));
    end
    check("m_rdat", 128'({p1_dat_o, p0_dat_o}), 128'({sdr_rdat, sdr_rdat}));
    check("m_bufw", 128'({p1_bufw_we_o, p0_bufw_we_o, bufw_sel_o, bufw_dat_o, bufw_adr_o}),
          128'({m_stb, m_bsel, m_bdat, m_badr}));
  endtask

  task automatic settle();
    @(negedge clk);
    model_compare();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    settle();
    clock_edge();
  endtask

  task automatic idle_all();
    acc = 2'b00; we = 2'b00; sdr_ack = 1'b0; sdr_rdat = 16'h0;
    for (int p = 0; p < 2; p++) begin
      adr[p] = 32'h0; dat[p] = 16'h0; sel[p] = 2'b00;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    clock_edge();
    clock_edge();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    settle();
    check("rst_ctl", 128'({sdr_acc_o, sdr_we_o, p1_ack_o, p0_ack_o}), 128'(4'h0));
    check("rst_bufw", 128'({p1_bufw_we_o, p0_bufw_we_o, bufw_sel_o, bufw_dat_o, bufw_adr_o}), 128'(0));
    clock_edge();

    // single 32-bit write from port 0
    acc[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h100; dat[0] = 16'hDEAD; sel[0] = 2'b11;
    settle(); check("t1_idle_acc", 128'(sdr_acc_o), 128'(1'b0)); clock_edge();
    settle(); check("t1_grant_acc", 128'(sdr_acc_o), 128'(1'b1));
    check("t1_hi_half", 128'(sdr_dat_o), 128'(16'hDEAD)); clock_edge();
    dat[0] = 16'hBEEF; adr[0] = 32'h102; sdr_ack = 1'b1;
    settle(); check("t1_ack", 128'({p1_ack_o, p0_ack_o}), 128'(2'b01)); clock_edge();
    idle_all();
    settle();
    check("t1_strobe", 128'({p1_bufw_we_o, p0_bufw_we_o}), 128'(2'b10));
    check("t1_badr", 128'(bufw_adr_o), 128'(32'h100));
    check("t1_bdat", 128'(bufw_dat_o), 128'(32'hDEADBEEF));
    check("t1_bsel", 128'(bufw_sel_o), 128'(4'hF));
    clock_edge();
    settle();
    check("t1_strobe_off", 128'({p1_bufw_we_o, p0_bufw_we_o}), 128'(2'b00));
    check("t1_bdat_hold", 128'(bufw_dat_o), 128'(32'hDEADBEEF));
    clock_edge();

    // simultaneous requests out of reset
    do_reset();
    acc = 2'b11; we = 2'b11;
    adr[0] = 32'h200; adr[1] = 32'h300; dat[0] = 16'h1111; dat[1] = 16'h2222;
    sel[0] = 2'b11; sel[1] = 2'b11;
    step();
    settle(); check("t2_first_p0", 128'({sdr_acc_o, sdr_adr_o}), 128'({1'b1, 32'h200})); clock_edge();
    dat[0] = 16'h3333; sdr_ack = 1'b1;
    settle(); check("t2_ack_p0", 128'({p1_ack_o, p0_ack_o}), 128'(2'b01)); clock_edge();
    sdr_ack = 1'b0;
    settle(); check("t2_gap", 128'(sdr_acc_o), 128'(1'b0)); clock_edge();
    settle(); check("t2_second_p1", 128'({sdr_acc_o, sdr_adr_o}), 128'({1'b1, 32'h300})); clock_edge();
    dat[1] = 16'h4444; sdr_ack = 1'b1;
    settle(); check("t2_ack_p1", 128'({p1_ack_o, p0_ack_o}), 128'(2'b10)); clock_edge();
    sdr_ack = 1'b0;
    settle(); check("t2_strobe_p0", 128'({p1_bufw_we_o, p0_bufw_we_o}), 128'(2'b01)); clock_edge();
    sdr_ack = 1'b1;
    settle(); check("t2_third_p0", 128'({sdr_acc_o, sdr_adr_o}), 128'({1'b1, 32'h200})); clock_edge();

    // two-burst read from port 1 with port 0 waiting
    idle_all(); acc[1] = 1'b1; adr[1] = 32'h400;
    step();
    acc[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h500; dat[0] = 16'h5555; sel[0] = 2'b11;
    sdr_ack = 1'b1; sdr_rdat = 16'hA5A5;
    settle();
    check("t3_ack1", 128'({p1_ack_o, p0_ack_o}), 128'(2'b10));
    check("t6_rbcast", 128'({p1_dat_o, p0_dat_o}), 128'(32'hA5A5A5A5));
    clock_edge();
    acc[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sdr_ack = (i == 1);
      settle();
      check("t3_gap_adr", 128'(sdr_adr_o), 128'(32'h400));
      check("t3_gap_p0ack", 128'(p0_ack_o), 128'(1'b0));
      clock_edge();
    end
    sdr_ack = 1'b0; acc[1] = 1'b1;
    step();
    sdr_ack = 1'b1;
    settle(); check("t3_ack2", 128'({p1_ack_o, p0_ack_o}), 128'(2'b10)); clock_edge();
    sdr_ack = 1'b0; acc[1] = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      settle();
      check("t3_held", 128'(sdr_adr_o), 128'(32'h400));
      check("t6_no_strobe", 128'({p1_bufw_we_o, p0_bufw_we_o}), 128'(2'b00));
      clock_edge();
    end
    settle(); check("t3_release", 128'(sdr_acc_o), 128'(1'b0)); clock_edge();
    settle();
    check("t3_p0_grant", 128'({sdr_acc_o, sdr_we_o, sdr_adr_o}), 128'({2'b11, 32'h500}));
    clock_edge();
    dat[0] = 16'h6666; sdr_ack = 1'b1;
    step();
    idle_all();
    step();

    // partial write from port 1
    acc[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h600; dat[1] = 16'h1234; sel[1] = 2'b01;
    step();
    step();
    dat[1] = 16'h5678; sel[1] = 2'b10; adr[1] = 32'h602; sdr_ack = 1'b1;
    step();
    idle_all();
    settle();
    check("t4_strobe", 128'({p1_bufw_we_o, p0_bufw_we_o}), 128'(2'b01));
    check("t4_bsel", 128'(bufw_sel_o), 128'(4'h6));
    check("t4_bdat", 128'(bufw_dat_o), 128'(32'h12345678));
    check("t4_badr", 128'(bufw_adr_o), 128'(32'h600));
    clock_edge();

    // reset on the write-ack cycle
    acc[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h700; dat[0] = 16'hAAAA; sel[0] = 2'b11;
    step();
    step();
    dat[0] = 16'hBBBB; sdr_ack = 1'b1; rst_n = 1'b0;
    step();
    idle_all(); rst_n = 1'b1; sdr_ack = 1'b1;
    settle();
    check("t5_no_strobe", 128'({p1_bufw_we_o, p0_bufw_we_o}), 128'(2'b00));
    check("t5_bufw_zero", 128'({bufw_sel_o, bufw_dat_o, bufw_adr_o}), 128'(0));
    check("t5_ctl", 128'({sdr_acc_o, sdr_we_o, p1_ack_o, p0_ack_o}), 128'(4'h0));
    clock_edge();
    idle_all();

    // randomized traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(3) == 0) acc[p] = ~acc[p];
        if ($urandom_range(7) == 0) we[p] = ~we[p];
        adr[p] = $urandom;
        dat[p] = 16'($urandom);
        sel[p] = 2'($urandom);
      end
      sdr_ack  = ($urandom_range(2) == 0);
      sdr_rdat = 16'($urandom);
      rst_n    = ($urandom_range(399) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
